ltc2624_responder: RTL and testbench

LTC2624_RESPONDER -- requirements
Module: ltc2624_responder

---
 rtl/ltc2624_responder_pkg.sv | 34 +++
 rtl/ltc2624_responder_if.sv | 13 +
 rtl/ltc2624_responder_sync_edge.sv | 25 ++
 rtl/ltc2624_responder.sv | 143 ++++++++++++++
 tb/tb_ltc2624_responder.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ltc2624_responder_pkg.sv
// Shared definitions for the LTC2624 DAC responder: command/address codes,
// frame length and FSM state encoding.
package ltc2624_responder_pkg;

  localparam logic [3:0] CMD_WR_IN  = 4'b0000;
  localparam logic [3:0] CMD_UPD    = 4'b0001;
  localparam logic [3:0] CMD_WR_UPD = 4'b0011;
  localparam logic [3:0] CMD_PWRDN  = 4'b0100;
  localparam logic [3:0] CMD_NOP    = 4'b1111;

  localparam logic [3:0] ADDR_ALL   = 4'b1111;
  localparam int unsigned FRAME_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Channel select mask, bit 0 = A ... bit 3 = D; unknown addresses select nothing.
  function automatic logic [3:0] addr_mask(input logic [3:0] addr);
    logic [3:0] m;
    case (addr)
      4'd0:     m = 4'b0001;
      4'd1:     m = 4'b0010;
      4'd2:     m = 4'b0100;
      4'd3:     m = 4'b1000;
      ADDR_ALL: m = 4'b1111;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ltc2624_responder_if.sv
// Serial DAC link between an initiator (master) and the LTC2624 responder (slave).
interface ltc2624_responder_if;
  logic SPI_SCK;
  logic DAC_CS;
  logic DAC_CLR;
  logic SPI_MOSI;
  logic DAC_OUT;

  modport master (output SPI_SCK, output DAC_CS, output DAC_CLR, output SPI_MOSI,
                  input DAC_OUT);
  modport slave  (input SPI_SCK, input DAC_CS, input DAC_CLR, input SPI_MOSI,
                  output DAC_OUT);
endinterface

// File: rtl/ltc2624_responder_sync_edge.sv
// Two-flop synchroniser with a third flop for edge detection on the
// synchronised level; RST_VAL sets the idle level loaded by reset.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= {3{RST_VAL}};
    else       sync_q <= {sync_q[1:0], d_i};
  end

  assign q_o    = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/ltc2624_responder.sv
// LTC2624 quad 12-bit DAC responder: decodes 32-bit SPI frames into input/output
// registers. Define LTC2624_ECHO_EN to enable the DAC_OUT serial echo.
module ltc2624_responder
  import ltc2624_responder_pkg::*;
(
  input  logic                 CLK50MHZ,
  input  logic                 RST,
  ltc2624_responder_if.slave   spi,
  output logic [47:0]          dac_val,
  output logic [3:0]           last_cmd,
  output logic [3:0]           last_addr,
  output logic                 frame_ok,
  output logic                 frame_err
);

  logic sck_q, sck_rise, sck_fall;
  logic cs_q, cs_rise, cs_fall;
  logic clr_q, clr_rise, clr_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  sync_edge #(.RST_VAL(1'b0)) u_sync_sck (.clk_i(CLK50MHZ), .rst_i(RST), .d_i(spi.SPI_SCK),
    .q_o(sck_q), .rise_o(sck_rise), .fall_o(sck_fall));
  sync_edge #(.RST_VAL(1'b1)) u_sync_cs (.clk_i(CLK50MHZ), .rst_i(RST), .d_i(spi.DAC_CS),
    .q_o(cs_q), .rise_o(cs_rise), .fall_o(cs_fall));
  sync_edge #(.RST_VAL(1'b1)) u_sync_clr (.clk_i(CLK50MHZ), .rst_i(RST), .d_i(spi.DAC_CLR),
    .q_o(clr_q), .rise_o(clr_rise), .fall_o(clr_fall));
  sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (.clk_i(CLK50MHZ), .rst_i(RST), .d_i(spi.SPI_MOSI),
    .q_o(mosi_q), .rise_o(mosi_rise), .fall_o(mosi_fall));

  state_e            state_q;
  logic [31:0]       sr_q;
  logic [5:0]        cnt_q, cnt_d;
  logic [3:0]        last_cmd_q, last_addr_q;
  logic              ok_q, err_q;
  logic [3:0][11:0]  in_q, in_d, out_q, out_d;
  logic              accept;

  assign cnt_d  = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
  assign accept = (state_q == ST_DONE) && (cnt_q == 6'(FRAME_BITS));

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      last_cmd_q  <= '0;
      last_addr_q <= '0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ok_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
          end
        end
        ST_SHIFT: begin
          if (sck_rise) begin
            sr_q  <= {sr_q[30:0], mosi_q};
            cnt_q <= cnt_d;
          end
          if (cs_rise) state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          if (accept) begin
            ok_q        <= 1'b1;
            last_cmd_q  <= sr_q[23:20];
            last_addr_q <= sr_q[19:16];
          end else begin
            err_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Clear is applied last so it overrides a frame committing in the same cycle.
  always_comb begin
    logic [3:0] mask;
    in_d  = in_q;
    out_d = out_q;
    mask  = addr_mask(sr_q[19:16]);
    if (accept) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (mask[ch]) begin
          case (sr_q[23:20])
            CMD_WR_IN:  in_d[ch] = sr_q[15:4];
            CMD_UPD:    out_d[ch] = in_q[ch];
            CMD_WR_UPD: begin
              in_d[ch]  = sr_q[15:4];
              out_d[ch] = sr_q[15:4];
            end
            CMD_PWRDN, CMD_NOP: ;
            default: ;
          endcase
        end
      end
    end
    if (!clr_q) begin
      in_d  = '0;
      out_d = '0;
    end
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      in_q  <= '0;
      out_q <= '0;
    end else begin
      in_q  <= in_d;
      out_q <= out_d;
    end
  end

`ifdef LTC2624_ECHO_EN
  logic echo_q;

  always_ff @(posedge CLK50MHZ) begin
    if (RST)                                    echo_q <= 1'b0;
    else if (state_q == ST_SHIFT && sck_fall)   echo_q <= sr_q[31];
  end

  assign spi.DAC_OUT = echo_q;
`else
  assign spi.DAC_OUT = 1'b0;
`endif

  assign dac_val   = out_q;
  assign last_cmd  = last_cmd_q;
  assign last_addr = last_addr_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;

  logic unused_sig;
  assign unused_sig = &{1'b0, sck_q, sck_fall, cs_q, clr_rise, clr_fall,
                        mosi_rise, mosi_fall, sr_q[31:24], sr_q[3:0]};

endmodule

// File: tb/tb_ltc2624_responder.sv
// Scoreboard bench for ltc2624_responder: stimulus queues expected frame
// results, a monitor compares them whenever frame_ok/frame_err pulses.
module tb_ltc2624_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] dac_val;
  logic [3:0]  last_cmd, last_addr;
  logic        frame_ok, frame_err;

  always #10 clk = ~clk;

  ltc2624_responder_if spi();

  ltc2624_responder dut (
    .CLK50MHZ (clk),
    .RST      (rst),
    .spi      (spi),
    .dac_val  (dac_val),
    .last_cmd (last_cmd),
    .last_addr(last_addr),
    .frame_ok (frame_ok),
    .frame_err(frame_err)
  );

  typedef struct {
    logic        ok;
    logic [47:0] dv;
    logic [3:0]  cmd;
    logic [3:0]  addr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cap;
  logic [31:0] echo_exp;
  logic        chk_gap = 1'b0;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic expect_frame(input logic ok, input logic [47:0] dv,
                              input logic [3:0] c, input logic [3:0] a);
    exp_t e;
    e.ok = ok; e.dv = dv; e.cmd = c; e.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [95:0] w, input int nbits);
    spi.DAC_CS = 1'b0;
    cyc(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi.SPI_MOSI = w[i];
      cyc(4);
      cap = {cap[30:0], spi.DAC_OUT};
      spi.SPI_SCK = 1'b1;
      cyc(4);
      spi.SPI_SCK = 1'b0;
    end
    cyc(4);
    spi.DAC_CS = 1'b1;
    cyc(10);
  endtask

  task automatic clear_pulse();
    spi.DAC_CLR = 1'b0;
    cyc(5);
    spi.DAC_CLR = 1'b1;
    cyc(4);
  endtask

  always @(negedge clk) begin
    if (chk_gap) begin
      chk("pulse_width", {46'd0, frame_ok, frame_err}, 48'd0);
      chk_gap = 1'b0;
    end
    if (frame_ok || frame_err) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: ok=%b err=%b with no frame expected", frame_ok, frame_err);
      end else begin
        cur = exp_q.pop_front();
        chk("frame_kind", {46'd0, frame_ok, frame_err}, {46'd0, cur.ok, ~cur.ok});
        chk("dac_val", dac_val, cur.dv);
        chk("last_cmd", {44'd0, last_cmd}, {44'd0, cur.cmd});
        chk("last_addr", {44'd0, last_addr}, {44'd0, cur.addr});
        chk_gap = 1'b1;
      end
    end
  end

  initial begin
    rst          = 1'b1;
    spi.SPI_SCK  = 1'b0;
    spi.DAC_CS   = 1'b1;
    spi.DAC_CLR  = 1'b1;
    spi.SPI_MOSI = 1'b0;
    cap          = '0;
    cyc(5);
    chk("rst_dac_val", dac_val, 48'd0);
    chk("rst_last", {40'd0, last_cmd, last_addr}, 48'd0);
    chk("rst_pulses", {46'd0, frame_ok, frame_err}, 48'd0);
    chk("rst_dac_out", {47'd0, spi.DAC_OUT}, 48'd0);
    rst = 1'b0;
    cyc(5);

    // write+update channel A
    expect_frame(1'b1, 48'h000_000_000_ABC, 4'h3, 4'h0);
    send({64'd0, 32'h0030_ABC0}, 32);

    clear_pulse();
    chk("clr_zero_1", dac_val, 48'd0);

    // input-only write to all, then update C only
    expect_frame(1'b1, 48'h000_000_000_000, 4'h0, 4'hF);
    send({64'd0, 32'h000F_5550}, 32);
    expect_frame(1'b1, 48'h000_555_000_000, 4'h1, 4'h2);
    send({64'd0, 32'h0012_0000}, 32);

    // short, long and saturating-length frames are all discarded
    expect_frame(1'b0, 48'h000_555_000_000, 4'h1, 4'h2);
    send({64'd0, 32'h0030_FFF0}, 31);
    expect_frame(1'b0, 48'h000_555_000_000, 4'h1, 4'h2);
    send({64'd0, 32'h0030_FFF0}, 33);
    expect_frame(1'b0, 48'h000_555_000_000, 4'h1, 4'h2);
    send({64'd0, 32'h0030_FFF0}, 96);

    // unknown address, unknown command, broadcast write+update
    expect_frame(1'b1, 48'h000_555_000_000, 4'h3, 4'h5);
    send({64'd0, 32'h0035_7770}, 32);
    expect_frame(1'b1, 48'h000_555_000_000, 4'h7, 4'h0);
    send({64'd0, 32'h0070_9990}, 32);
    expect_frame(1'b1, 48'h246_246_246_246, 4'h3, 4'hF);
    send({64'd0, 32'h003F_2460}, 32);
    expect_frame(1'b1, 48'h246_246_246_246, 4'h0, 4'hF);
    send({64'd0, 32'h000F_7AA0}, 32);

    clear_pulse();
    chk("clr_zero_2", dac_val, 48'd0);
    expect_frame(1'b1, 48'h000_000_123_000, 4'h3, 4'h1);
    send({64'd0, 32'h0031_1230}, 32);
    // input registers must have been cleared too (no 0x7AA left behind)
    expect_frame(1'b1, 48'h000_000_123_000, 4'h1, 4'hF);
    send({64'd0, 32'h001F_0000}, 32);

    // echo: W1 then W2, DAC_OUT captured on SCK rises during W2
    expect_frame(1'b1, 48'h000_000_123_000, 4'h3, 4'h4);
    send({64'd0, 32'h1234_5678}, 32);
    cap = '0;
    expect_frame(1'b1, 48'h000_000_123_000, 4'h0, 4'h0);
    send({64'd0, 32'h0000_0000}, 32);
`ifdef LTC2624_ECHO_EN
    echo_exp = 32'h1234_5678;
`else
    echo_exp = 32'h0000_0000;
`endif
    chk("echo", {16'd0, cap}, {16'd0, echo_exp});

    // reset in the middle of a frame
    spi.DAC_CS = 1'b0;
    cyc(4);
    for (int i = 31; i >= 16; i--) begin
      spi.SPI_MOSI = (i == 21 || i == 20) ? 1'b1 : 1'b0;
      cyc(4);
      spi.SPI_SCK = 1'b1;
      cyc(4);
      spi.SPI_SCK = 1'b0;
    end
    rst = 1'b1;
    cyc(2);
    spi.DAC_CS = 1'b1;
    cyc(4);
    chk("midrst_dac_val", dac_val, 48'd0);
    chk("midrst_last", {40'd0, last_cmd, last_addr}, 48'd0);
    rst = 1'b0;
    cyc(6);
    expect_frame(1'b1, 48'h000_000_000_ABC, 4'h3, 4'h0);
    send({64'd0, 32'h0030_ABC0}, 32);

    cyc(20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_frames: %0d expected frames never observed, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
